// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: pcsource encodings,
// default reset PC and the fetch FSM state type.
package fetch_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// SRAM-like instruction bus: one request/address handshake, one data return.
interface fetch_unit_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Redirect-target select and next fetch address choice (target or +4).
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jrpc,
  input  logic [31:0] jpc,
  input  logic [31:0] fetch_pc,
  input  logic        redir_pend,
  input  logic [31:0] redir_tgt,
  input  logic        redirect,
  output logic [31:0] target,
  output logic [31:0] next_pc
);

  always_comb begin
    target = fetch_pc + 32'd4;
    case (pcsource)
      PCSRC_BR: target = bpc;
      PCSRC_JR: target = jrpc;
      PCSRC_J:  target = jpc;
      default:  target = fetch_pc + 32'd4;
    endcase
  end

  // A pending target wins; otherwise a redirect accepted in the same cycle as
  // the delay-slot handshake steers the fetch PC directly.
  assign next_pc = redir_pend ? redir_tgt :
                   redirect   ? target    : fetch_pc + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage with delay-slot redirect handling.
// Optional FETCH_ADDR_CHECK_EN: misaligned fetch PC raises o_adel and halts fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic [1:0]   pcsource,
  input  logic [31:0]  bpc,
  input  logic [31:0]  jrpc,
  input  logic [31:0]  jpc,
  fetch_unit_if.master ibus,
  output logic         o_valid,
  output logic [31:0]  o_pc,
  output logic [31:0]  o_inst,
  output logic         o_adel
);

  fetch_state_t state_reg;
  logic [31:0]  fetch_pc_reg;
  logic [31:0]  req_pc_reg;
  logic [31:0]  redir_tgt_reg;
  logic         redir_pend_reg;

  logic         accept;
  logic         slot_free;
  logic         redirect;
  logic         issue;
  logic         handshake;
  logic         data_load;
  logic         adel_load;
  logic         halted;
  logic [31:0]  target;
  logic [31:0]  next_pc;

  assign accept    = o_valid & ~stall;
  assign slot_free = ~o_valid | accept;
  assign redirect  = accept & (pcsource != PCSRC_SEQ);
  assign data_load = (state_reg == WAIT) & ibus.inst_data_ok;

`ifdef FETCH_ADDR_CHECK_EN
  logic halt_reg;
  logic can_fetch;
  logic misaligned;

  assign misaligned     = fetch_pc_reg[1:0] != 2'b00;
  assign can_fetch      = (state_reg == IDLE) & ~reset & slot_free & ~halt_reg;
  assign issue          = can_fetch & ~misaligned;
  assign adel_load      = can_fetch & misaligned;
  assign halted         = halt_reg;
  assign ibus.inst_addr = fetch_pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      halt_reg <= 1'b0;
      o_adel   <= 1'b0;
    end else begin
      if (adel_load)
        halt_reg <= 1'b1;
      else if (halt_reg & redirect)
        halt_reg <= 1'b0;

      if (data_load)
        o_adel <= 1'b0;
      else if (adel_load)
        o_adel <= 1'b1;
      else if (accept)
        o_adel <= 1'b0;
    end
  end
`else
  assign issue          = (state_reg == IDLE) & ~reset & slot_free;
  assign adel_load      = 1'b0;
  assign halted         = 1'b0;
  assign ibus.inst_addr = {fetch_pc_reg[31:2], 2'b00};
  assign o_adel         = 1'b0;
`endif

  assign ibus.inst_req = issue | ((state_reg == REQ) & ~reset);
  assign handshake     = ibus.inst_req & ibus.inst_addr_ok;

  fetch_next_pc u_next_pc (
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jrpc       (jrpc),
    .jpc        (jpc),
    .fetch_pc   (fetch_pc_reg),
    .redir_pend (redir_pend_reg),
    .redir_tgt  (redir_tgt_reg),
    .redirect   (redirect),
    .target     (target),
    .next_pc    (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      req_pc_reg     <= 32'd0;
      redir_pend_reg <= 1'b0;
      redir_tgt_reg  <= 32'd0;
      o_valid        <= 1'b0;
      o_pc           <= 32'd0;
      o_inst         <= 32'd0;
    end else begin
      unique case (state_reg)
        IDLE:    if (issue) state_reg <= handshake ? WAIT : REQ;
        REQ:     if (handshake) state_reg <= WAIT;
        WAIT:    if (ibus.inst_data_ok) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (handshake) begin
        req_pc_reg   <= fetch_pc_reg;
        fetch_pc_reg <= next_pc;
      end else if (halted & redirect) begin
        fetch_pc_reg <= target;
      end

      // The delay-slot handshake consumes any pending redirect target.
      if (handshake | (halted & redirect)) begin
        redir_pend_reg <= 1'b0;
      end else if (redirect) begin
        redir_pend_reg <= 1'b1;
        redir_tgt_reg  <= target;
      end

      if (data_load) begin
        o_valid <= 1'b1;
        o_pc    <= req_pc_reg;
        o_inst  <= ibus.inst_rdata;
      end else if (adel_load) begin
        o_valid <= 1'b1;
        o_pc    <= fetch_pc_reg;
        o_inst  <= 32'd0;
      end else if (accept) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bus responder, decode model and a
// program-order reference model of the delivered instruction stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'd0, jrpc = 32'd0, jpc = 32'd0;
  logic        o_valid, o_adel;
  logic [31:0] o_pc, o_inst;

  fetch_unit_if ibus();

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pcsource(pcsource),
    .bpc(bpc), .jrpc(jrpc), .jpc(jpc), .ibus(ibus),
    .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst), .o_adel(o_adel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // decode-side configuration
  bit          rand_stall = 0;
  int          stall_pct = 0;
  bit          force_stall = 0;
  int          branch_pct = 0;
  bit          force_en = 0;
  logic [31:0] force_pc;
  logic [1:0]  force_src;
  logic [31:0] force_tgt;

  // memory-side configuration and state
  int          addr_min = 0, addr_max = 0, data_min = 1, data_max = 1;
  bit          stray_data = 0;
  bit          hold_addr = 0;
  bit          req_active = 0;
  int          addr_wait = 0;
  bit          bus_out = 0;
  int          data_cnt = 0;
  logic [31:0] out_addr;
  bit          proto_err = 0;

  // reference model: expected PC of the next delivered instruction
  logic [31:0] exp_pc = RPC;
  logic [31:0] tgt_save = 32'd0;
  bit          slot_pending = 0;

  // per-cycle observations
  bit          acc_fire, hs_fire, held_req;
  logic [31:0] acc_pc, acc_inst, acc_exp, hs_addr, held_addr;
  logic        acc_adel;
  bit          req_prev = 0, prev_hs = 0;
  logic [31:0] addr_prev = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return {w[15:0], w[31:16]} ^ 32'h3C1D_5A96;
  endfunction

  function automatic logic [31:0] rand_tgt();
    return {16'hBFC0, 14'($urandom_range(64, 16383)), 2'b00};
  endfunction

  task automatic step();
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] sel;
    @(negedge clk);
    // decode side
    pcsource = PCSRC_SEQ;
    bpc  = rand_tgt();
    jrpc = rand_tgt();
    jpc  = rand_tgt();
    stall = force_stall ? 1'b1 : (rand_stall ? ($urandom_range(0, 99) < stall_pct) : 1'b0);
    if (o_valid && !slot_pending) begin
      src = PCSRC_SEQ;
      tgt = 32'd0;
      if (force_en && o_pc == force_pc) begin
        src = force_src;
        tgt = force_tgt;
      end else if ($urandom_range(0, 99) < branch_pct) begin
        src = 2'($urandom_range(1, 3));
        tgt = rand_tgt();
      end
      pcsource = src;
      if (src == PCSRC_BR) bpc = tgt;
      if (src == PCSRC_JR) jrpc = tgt;
      if (src == PCSRC_J)  jpc = tgt;
    end
    #1;
    // memory side
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b0;
    ibus.inst_rdata   = $urandom;
    if (reset) begin
      bus_out = 0;
      req_active = 0;
    end else begin
      if (bus_out) begin
        if (data_cnt <= 1) begin
          ibus.inst_data_ok = 1'b1;
          ibus.inst_rdata   = mem_word(out_addr);
          bus_out = 0;
        end else begin
          data_cnt--;
        end
      end
      if (ibus.inst_req) begin
        if (bus_out) proto_err = 1;
        if (!req_active) begin
          req_active = 1;
          addr_wait = $urandom_range(addr_min, addr_max);
        end
        if (addr_wait == 0 && !hold_addr) begin
          ibus.inst_addr_ok = 1'b1;
          req_active = 0;
          bus_out = 1;
          data_cnt = $urandom_range(data_min, data_max);
          out_addr = ibus.inst_addr;
        end else if (addr_wait > 0) begin
          addr_wait--;
        end
      end
    end
    if (stray_data) begin
      ibus.inst_data_ok = 1'b1;
      ibus.inst_rdata   = 32'hDEAD_BEEF;
    end
    #1;
    // observe and advance the reference model
    held_req  = req_prev && !prev_hs && !reset;
    held_addr = addr_prev;
    hs_fire   = ibus.inst_req && ibus.inst_addr_ok;
    hs_addr   = ibus.inst_addr;
    acc_fire  = o_valid && !stall && !reset;
    if (acc_fire) begin
      acc_pc   = o_pc;
      acc_inst = o_inst;
      acc_adel = o_adel;
      acc_exp  = exp_pc;
      if (slot_pending) begin
        exp_pc = tgt_save;
        slot_pending = 0;
      end else begin
        exp_pc = acc_exp + 32'd4;
      end
      if (pcsource != PCSRC_SEQ) begin
        sel = (pcsource == PCSRC_BR) ? bpc : (pcsource == PCSRC_JR) ? jrpc : jpc;
        tgt_save = sel;
        slot_pending = 1;
      end
    end
    if (reset) begin
      exp_pc = RPC;
      slot_pending = 0;
    end
    req_prev  = ibus.inst_req;
    addr_prev = ibus.inst_addr;
    prev_hs   = hs_fire;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    proto_err = 0;
  endtask

  task automatic set_mem(input int amin, input int amax, input int dmin, input int dmax);
    addr_min = amin; addr_max = amax; data_min = dmin; data_max = dmax;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (o_valid !== 1'b0 || ibus.inst_req !== 1'b0 || o_adel !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got valid=%b req=%b adel=%b want 0 0 0", o_valid, ibus.inst_req, o_adel);
    end
    checks++;
    if (o_pc !== 32'd0 || o_inst !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs got pc=%h inst=%h want 0 0", o_pc, o_inst);
    end
    reset = 1'b0;
    step();
    checks++;
    if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== RPC || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req got req=%b addr=%h valid=%b want 1 %h 0", ibus.inst_req, ibus.inst_addr, o_valid, RPC);
    end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    int nhs = 0;
    set_mem(0, 0, 1, 1);
    rand_stall = 0; branch_pct = 0; force_en = 0; force_stall = 0;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      step();
      checks++;
      if (o_valid !== ((k > 0) && (k % 2 == 0))) begin
        errors++;
        $display("FAIL seq_valid cycle %0d got %b want %b", k, o_valid, (k > 0) && (k % 2 == 0));
      end
      checks++;
      if (hs_fire !== (k % 2 == 0)) begin
        errors++;
        $display("FAIL seq_hs cycle %0d got %b want %b", k, hs_fire, k % 2 == 0);
      end
      if (hs_fire) begin
        checks++;
        if (hs_addr !== RPC + 32'(4 * nhs)) begin
          errors++;
          $display("FAIL seq_addr got %h want %h", hs_addr, RPC + 32'(4 * nhs));
        end
        nhs++;
      end
      if (acc_fire) begin
        checks++;
        if (acc_pc !== acc_exp || acc_inst !== mem_word(acc_exp)) begin
          errors++;
          $display("FAIL seq_out got pc=%h inst=%h want %h %h", acc_pc, acc_inst, acc_exp, mem_word(acc_exp));
        end
      end
    end
    $display("test_sequential done handshakes=%0d", nhs);
  endtask

  task automatic test_stall();
    int n = 0;
    logic [31:0] hold_pc, hold_inst;
    force_stall = 1;
    while (!o_valid && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (!o_valid) begin
      errors++;
      $display("FAIL stall_wait got valid=0 want 1 within 10 cycles");
    end
    hold_pc = o_pc;
    hold_inst = o_inst;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (o_valid !== 1'b1 || o_pc !== hold_pc || o_inst !== hold_inst || ibus.inst_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got valid=%b pc=%h inst=%h req=%b want 1 %h %h 0",
                 o_valid, o_pc, o_inst, ibus.inst_req, hold_pc, hold_inst);
      end
    end
    force_stall = 0;
    step();
    checks++;
    if (!acc_fire || ibus.inst_req !== 1'b1 || acc_pc !== acc_exp) begin
      errors++;
      $display("FAIL stall_release got acc=%b req=%b pc=%h want 1 1 %h", acc_fire, ibus.inst_req, acc_pc, acc_exp);
    end
    $display("test_stall done pc=%h", hold_pc);
  endtask

  task automatic run_redirect(input string name, input logic [31:0] bpc_at, input logic [1:0] src,
                              input logic [31:0] tgt, input int nexp, input logic [31:0] exp_list [8]);
    logic [31:0] got [$];
    int n = 0;
    force_en = 1; force_pc = bpc_at; force_src = src; force_tgt = tgt;
    do_reset();
    while (got.size() < nexp && n < 300) begin
      step();
      n++;
      if (held_req) begin
        checks++;
        if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== held_addr) begin
          errors++;
          $display("FAIL %s_hold got req=%b addr=%h want 1 %h", name, ibus.inst_req, ibus.inst_addr, held_addr);
        end
      end
      if (hs_fire) got.push_back(hs_addr);
      if (acc_fire) begin
        checks++;
        if (acc_pc !== acc_exp || acc_inst !== mem_word(acc_exp)) begin
          errors++;
          $display("FAIL %s_out got pc=%h inst=%h want %h %h", name, acc_pc, acc_inst, acc_exp, mem_word(acc_exp));
        end
      end
    end
    checks++;
    if (got.size() != nexp) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", name, got.size(), nexp);
    end
    for (int i = 0; i < got.size() && i < nexp; i++) begin
      checks++;
      if (got[i] !== exp_list[i]) begin
        errors++;
        $display("FAIL %s_addr[%0d] got %h want %h", name, i, got[i], exp_list[i]);
      end
    end
    force_en = 0;
    $display("%s done handshakes=%0d", name, got.size());
  endtask

  task automatic test_branch();
    logic [31:0] el [8];
    el = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C,
           32'hBFC00010, 32'hBFC00014, 32'hBFC00100, 32'hBFC00104};
    set_mem(0, 0, 1, 1);
    rand_stall = 0; branch_pct = 0;
    run_redirect("test_branch", 32'hBFC00010, PCSRC_BR, 32'hBFC00100, 8, el);
  endtask

  task automatic test_delayed_addr();
    logic [31:0] el [8];
    el = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C,
           32'hBFC00200, 32'hBFC00204, 32'h0, 32'h0};
    set_mem(3, 3, 1, 2);
    rand_stall = 1; stall_pct = 50; branch_pct = 0;
    run_redirect("test_delayed_addr", 32'hBFC00008, PCSRC_J, 32'hBFC00200, 6, el);
    rand_stall = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit seen = 0;
    set_mem(0, 0, 5, 5);
    rand_stall = 0; branch_pct = 0;
    do_reset();
    step();
    step();
    reset = 1'b1;
    step();
    stray_data = 1;
    step();
    reset = 1'b0;
    hold_addr = 1;
    step();
    checks++;
    if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== RPC || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_req got req=%b addr=%h valid=%b want 1 %h 0", ibus.inst_req, ibus.inst_addr, o_valid, RPC);
    end
    stray_data = 0;
    hold_addr = 0;
    set_mem(0, 0, 1, 1);
    step();
    checks++;
    if (o_valid !== 1'b0 || !hs_fire || hs_addr !== RPC) begin
      errors++;
      $display("FAIL rmid_stray got valid=%b hs=%b addr=%h want 0 1 %h", o_valid, hs_fire, hs_addr, RPC);
    end
    while (!seen && n < 20) begin
      step();
      n++;
      if (acc_fire) begin
        seen = 1;
        checks++;
        if (acc_pc !== RPC || acc_inst !== mem_word(RPC)) begin
          errors++;
          $display("FAIL rmid_first got pc=%h inst=%h want %h %h", acc_pc, acc_inst, RPC, mem_word(RPC));
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rmid_timeout got no instruction want one within 20 cycles");
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int naccs = 0;
    set_mem(0, 3, 1, 3);
    rand_stall = 1; stall_pct = 30; branch_pct = 20; force_en = 0;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step();
      if (held_req) begin
        checks++;
        if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== held_addr) begin
          errors++;
          $display("FAIL rand_hold got req=%b addr=%h want 1 %h", ibus.inst_req, ibus.inst_addr, held_addr);
        end
      end
      if (proto_err) begin
        checks++;
        errors++;
        proto_err = 0;
        $display("FAIL rand_outstanding got request while busy want none");
      end
      if (acc_fire) begin
        naccs++;
        checks++;
        if (acc_pc !== acc_exp || acc_inst !== mem_word(acc_exp) || acc_adel !== 1'b0) begin
          errors++;
          $display("FAIL rand_out got pc=%h inst=%h adel=%b want %h %h 0",
                   acc_pc, acc_inst, acc_adel, acc_exp, mem_word(acc_exp));
        end
      end
    end
    checks++;
    if (naccs < 60) begin
      errors++;
      $display("FAIL rand_progress got %0d instructions want at least 60", naccs);
    end
    rand_stall = 0; branch_pct = 0;
    $display("test_random done instructions=%0d", naccs);
  endtask

  task automatic test_addr_check();
    int n = 0;
    bit seen = 0;
    set_mem(0, 0, 1, 1);
    rand_stall = 0; branch_pct = 0;
    force_en = 1; force_pc = 32'hBFC00004; force_src = PCSRC_JR; force_tgt = 32'hBFC00102;
`ifdef FETCH_ADDR_CHECK_EN
    do_reset();
    while (!seen && n < 40) begin
      step();
      n++;
      if (acc_fire) begin
        checks++;
        if (acc_pc !== acc_exp || acc_adel !== 1'b0) begin
          errors++;
          $display("FAIL adel_pre got pc=%h adel=%b want %h 0", acc_pc, acc_adel, acc_exp);
        end
        if (acc_pc == 32'hBFC00008) seen = 1;
      end
    end
    force_stall = 1;
    n = 0;
    while (!o_valid && n < 10) begin
      step();
      n++;
      checks++;
      if (ibus.inst_req !== 1'b0) begin
        errors++;
        $display("FAIL adel_noreq got req=%b addr=%h want 0", ibus.inst_req, ibus.inst_addr);
      end
    end
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'hBFC00102 || o_inst !== 32'd0 || o_adel !== 1'b1) begin
      errors++;
      $display("FAIL adel_out got valid=%b pc=%h inst=%h adel=%b want 1 bfc00102 0 1", o_valid, o_pc, o_inst, o_adel);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (ibus.inst_req !== 1'b0) begin
        errors++;
        $display("FAIL adel_halt got req=%b want 0", ibus.inst_req);
      end
    end
    force_pc = 32'hBFC00102; force_src = PCSRC_J; force_tgt = 32'hBFC00300;
    force_stall = 0;
    step();
    step();
    checks++;
    if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hBFC00300) begin
      errors++;
      $display("FAIL adel_resume got req=%b addr=%h want 1 bfc00300", ibus.inst_req, ibus.inst_addr);
    end
`else
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step();
      if (hs_fire) begin
        checks++;
        if (hs_addr[1:0] !== 2'b00) begin
          errors++;
          $display("FAIL noadel_addr got %h want low bits 00", hs_addr);
        end
      end
      if (acc_fire) begin
        if (acc_pc == 32'hBFC00102) seen = 1;
        checks++;
        if (acc_pc !== acc_exp || acc_inst !== mem_word(acc_exp) || acc_adel !== 1'b0) begin
          errors++;
          $display("FAIL noadel_out got pc=%h inst=%h adel=%b want %h %h 0",
                   acc_pc, acc_inst, acc_adel, acc_exp, mem_word(acc_exp));
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL noadel_target got no instruction at bfc00102 want one");
    end
`endif
    force_en = 0;
    $display("test_addr_check done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b0;
    ibus.inst_rdata   = 32'd0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_delayed_addr();
    test_reset_mid();
    test_random();
    test_addr_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
